// File: rtl/turn_signal_sequencer.sv
// Tail-light sequencer: a divided step tick drives a left/right/hazard FSM whose
// step counter is rendered as a sequential or flash lamp pattern, with a brake
// overlay and a count of completed pattern periods.
module turn_signal_sequencer #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 2_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             left_req,
    input  logic             right_req,
    input  logic             hazard_req,
    input  logic             brake,
    input  logic             mode,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic [2:0]       state_code,
    output logic [3:0]       seq_count
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0] LAST_SEQ = 4'(LAMPS);
    localparam logic [LAMPS-1:0] ALL_ON = {LAMPS{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } state_t;

    logic [DIV_W-1:0] divCount_q;
    logic             tick;
    state_t           state_q, state_d, reqState;
    logic [3:0]       step_q, step_d;
    logic             mode_q, mode_d;
    logic [3:0]       seqCount_q, seqCount_d;
    logic [3:0]       lastStep;
    logic [LAMPS-1:0] activePat;
    logic [LAMPS-1:0] lampL_q, lampL_d;
    logic [LAMPS-1:0] lampR_q, lampR_d;
    logic [1:0]       stateCode_q;

    assign tick = (divCount_q == DIV_LAST);

    // Free-running step divider producing a one-cycle tick every TICK_DIV cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            divCount_q <= '0;
        end else if (tick) begin
            divCount_q <= '0;
        end else begin
            divCount_q <= divCount_q + DIV_W'(1);
        end
    end

    // State, step, latched pattern mode and period counter advance only on ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            mode_q     <= 1'b0;
            seqCount_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            seqCount_q <= seqCount_d;
        end
    end

    // Request priority decode and step/period bookkeeping for the next tick.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        mode_d     = mode_q;
        seqCount_d = seqCount_q;

        if (hazard_req || (left_req && right_req)) begin
            reqState = HAZARD;
        end else if (left_req) begin
            reqState = LEFT;
        end else if (right_req) begin
            reqState = RIGHT;
        end else begin
            reqState = IDLE;
        end

        lastStep = (state_q == HAZARD || mode_q) ? 4'd1 : LAST_SEQ;

        if (tick) begin
            state_d = reqState;
            mode_d  = mode;
            if (reqState == IDLE) begin
                step_d = 4'd0;
            end else if (reqState != state_q) begin
                step_d = 4'd1;
            end else if (reqState != HAZARD && mode != mode_q) begin
                step_d = 4'd1;
            end else if (step_q == lastStep) begin
                step_d     = 4'd0;
                seqCount_d = seqCount_q + 4'd1;
            end else begin
                step_d = step_q + 4'd1;
            end
        end
    end

    // Lamp image for the current state and step, with the brake overlay applied.
    always_comb begin
        activePat = '0;
        lampL_d   = '0;
        lampR_d   = '0;

        if (state_q == HAZARD || mode_q) begin
            activePat = (step_q == 4'd1) ? ALL_ON : '0;
        end else begin
            for (int i = 0; i < LAMPS; i++) begin
                activePat[i] = (4'(i) < step_q);
            end
        end

        case (state_q)
            IDLE: begin
                lampL_d = brake ? ALL_ON : '0;
                lampR_d = brake ? ALL_ON : '0;
            end
            LEFT: begin
                lampL_d = activePat;
                lampR_d = brake ? ALL_ON : '0;
            end
            RIGHT: begin
                lampL_d = brake ? ALL_ON : '0;
                lampR_d = activePat;
            end
            default: begin
                lampL_d = activePat;
                lampR_d = activePat;
            end
        endcase
    end

    // Registered lamp and state-code outputs, one cycle behind the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lampL_q     <= '0;
            lampR_q     <= '0;
            stateCode_q <= 2'd0;
        end else begin
            lampL_q     <= lampL_d;
            lampR_q     <= lampR_d;
            stateCode_q <= state_q;
        end
    end

    assign lamp_l     = lampL_q;
    assign lamp_r     = lampR_q;
    assign state_code = {1'b0, stateCode_q};
    assign seq_count  = seqCount_q;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed bench for turn_signal_sequencer with LAMPS=3, TICK_DIV=4.
// Lamp updates for tick j become visible on the falling edge after rising edge
// 4*j+1, counting the edge that sampled reset as edge 0.
module tb_turn_signal_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       left_req = 1'b0;
    logic       right_req = 1'b0;
    logic       hazard_req = 1'b0;
    logic       brake = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] lamp_l;
    logic [2:0] lamp_r;
    logic [2:0] state_code;
    logic [3:0] seq_count;

    int total = 0;
    int bad = 0;

    turn_signal_sequencer #(.LAMPS(3), .TICK_DIV(4)) dut (
        .clock(clock),
        .reset(reset),
        .left_req(left_req),
        .right_req(right_req),
        .hazard_req(hazard_req),
        .brake(brake),
        .mode(mode),
        .lamp_l(lamp_l),
        .lamp_r(lamp_r),
        .state_code(state_code),
        .seq_count(seq_count)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL timeout simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    // Apply inputs and one cycle of reset; returns on the falling edge after the reset edge.
    task automatic resetDut(input logic l, input logic r, input logic h, input logic b, input logic m);
        left_req   = l;
        right_req  = r;
        hazard_req = h;
        brake      = b;
        mode       = m;
        reset      = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        resetDut(0, 0, 0, 0, 0);
        total++;
        if ({lamp_l, lamp_r, state_code, seq_count} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_state got l=%b r=%b code=%0d seq=%0d want all 0", lamp_l, lamp_r, state_code, seq_count);
        end
        waitCycles(5);
        total++;
        if ({lamp_l, lamp_r, state_code, seq_count} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL idle_dark got l=%b r=%b code=%0d seq=%0d want all 0", lamp_l, lamp_r, state_code, seq_count);
        end
    endtask

    task automatic test_left_seq;
        logic [2:0] expL [5];
        logic [3:0] expS [5];
        expL = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        expS = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
        resetDut(1, 0, 0, 0, 0);
        waitCycles(1);
        for (int t = 0; t < 5; t++) begin
            waitCycles(4);
            total++;
            if ({lamp_l, lamp_r, state_code, seq_count} !== {expL[t], 3'b000, 3'd1, expS[t]}) begin
                bad++;
                $display("[TB] FAIL left_seq_t%0d got l=%b r=%b code=%0d seq=%0d want l=%b r=000 code=1 seq=%0d",
                         t + 1, lamp_l, lamp_r, state_code, seq_count, expL[t], expS[t]);
            end
        end
    endtask

    task automatic test_brake;
        resetDut(1, 0, 0, 0, 0);
        waitCycles(5);
        brake = 1'b1;
        waitCycles(1);
        total++;
        if ({lamp_l, lamp_r, state_code} !== {3'b001, 3'b111, 3'd1}) begin
            bad++;
            $display("[TB] FAIL brake_left got l=%b r=%b code=%0d want l=001 r=111 code=1", lamp_l, lamp_r, state_code);
        end
        left_req = 1'b0;
        waitCycles(3);
        total++;
        if ({lamp_l, lamp_r, state_code} !== {3'b111, 3'b111, 3'd0}) begin
            bad++;
            $display("[TB] FAIL brake_idle got l=%b r=%b code=%0d want l=111 r=111 code=0", lamp_l, lamp_r, state_code);
        end
        brake = 1'b0;
        waitCycles(1);
        total++;
        if ({lamp_l, lamp_r, state_code} !== {3'b000, 3'b000, 3'd0}) begin
            bad++;
            $display("[TB] FAIL brake_release got l=%b r=%b code=%0d want l=000 r=000 code=0", lamp_l, lamp_r, state_code);
        end
    endtask

    task automatic test_right_flash;
        logic [2:0] expR [3];
        expR = '{3'b111, 3'b000, 3'b111};
        resetDut(0, 1, 0, 0, 1);
        waitCycles(1);
        for (int t = 0; t < 3; t++) begin
            waitCycles(4);
            total++;
            if ({lamp_l, lamp_r, state_code} !== {3'b000, expR[t], 3'd2}) begin
                bad++;
                $display("[TB] FAIL right_flash_t%0d got l=%b r=%b code=%0d want l=000 r=%b code=2",
                         t + 1, lamp_l, lamp_r, state_code, expR[t]);
            end
        end
        mode = 1'b0;
        waitCycles(4);
        total++;
        if ({lamp_l, lamp_r, state_code, seq_count} !== {3'b000, 3'b001, 3'd2, 4'd1}) begin
            bad++;
            $display("[TB] FAIL mode_restart got l=%b r=%b code=%0d seq=%0d want l=000 r=001 code=2 seq=1",
                     lamp_l, lamp_r, state_code, seq_count);
        end
    endtask

    task automatic test_hazard;
        logic [2:0] expP [3];
        expP = '{3'b111, 3'b000, 3'b111};
        resetDut(1, 1, 0, 1, 0);
        waitCycles(1);
        for (int t = 0; t < 3; t++) begin
            waitCycles(4);
            total++;
            if ({lamp_l, lamp_r, state_code} !== {expP[t], expP[t], 3'd3}) begin
                bad++;
                $display("[TB] FAIL hazard_t%0d got l=%b r=%b code=%0d want l=%b r=%b code=3",
                         t + 1, lamp_l, lamp_r, state_code, expP[t], expP[t]);
            end
        end
        total++;
        if (seq_count !== 4'd1) begin
            bad++;
            $display("[TB] FAIL hazard_seq got seq=%0d want 1", seq_count);
        end
    endtask

    task automatic test_reset_mid;
        resetDut(1, 0, 0, 0, 0);
        waitCycles(1 + 4 * 6);
        total++;
        if ({lamp_l, seq_count} !== {3'b011, 4'd1}) begin
            bad++;
            $display("[TB] FAIL pre_reset got l=%b seq=%0d want l=011 seq=1", lamp_l, seq_count);
        end
        resetDut(1, 0, 0, 0, 0);
        total++;
        if ({lamp_l, lamp_r, state_code, seq_count} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset got l=%b r=%b code=%0d seq=%0d want all 0", lamp_l, lamp_r, state_code, seq_count);
        end
        waitCycles(4);
        total++;
        if ({lamp_l, state_code} !== {3'b000, 3'd0}) begin
            bad++;
            $display("[TB] FAIL post_reset_early got l=%b code=%0d want l=000 code=0", lamp_l, state_code);
        end
        waitCycles(1);
        total++;
        if ({lamp_l, state_code, seq_count} !== {3'b001, 3'd1, 4'd0}) begin
            bad++;
            $display("[TB] FAIL post_reset_tick got l=%b code=%0d seq=%0d want l=001 code=1 seq=0", lamp_l, state_code, seq_count);
        end
    endtask

    task automatic test_pulse;
        resetDut(0, 0, 0, 0, 0);
        waitCycles(1);
        left_req = 1'b1;
        waitCycles(2);
        left_req = 1'b0;
        waitCycles(2);
        total++;
        if ({lamp_l, lamp_r, state_code} !== {3'b000, 3'b000, 3'd0}) begin
            bad++;
            $display("[TB] FAIL pulse_ignored got l=%b r=%b code=%0d want l=000 r=000 code=0", lamp_l, lamp_r, state_code);
        end
        waitCycles(4);
        total++;
        if ({lamp_l, lamp_r, state_code} !== {3'b000, 3'b000, 3'd0}) begin
            bad++;
            $display("[TB] FAIL pulse_later got l=%b r=%b code=%0d want l=000 r=000 code=0", lamp_l, lamp_r, state_code);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_left_seq();
        test_brake();
        test_right_flash();
        test_hazard();
        test_reset_mid();
        test_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turn_signal_sequencer.md
Name: turn_signal_sequencer

Overview:
- Parametrised tail-light controller for the board lamp bank. Generalises the fixed left/right/hazard lamp FSM.
- Adds configurable lamps per side, configurable step rate and a built-in tick divider.
- Adds a selectable sequential or flash pattern, a brake overlay and a completed-sequence counter.
- Drives LEDR-style lamp outputs directly and provides a state code for the HEX decoder.

Parameters:
- LAMPS, 3: lamps per side, 1..8. Lamp[0] is innermost.
- TICK_DIV, 2_000_000: clock cycles per pattern step (5 Hz at 10 MHz). Minimum 2.

Ports:
- clock, input, 1: single system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- left_req, input, 1: left turn request, level.
- right_req, input, 1: right turn request, level.
- hazard_req, input, 1: hazard request, level.
- brake, input, 1: brake pedal, level.
- mode, input, 1: 0 = sequential pattern, 1 = flash pattern (turn states only).
- lamp_l, output, LAMPS: left lamps, registered.
- lamp_r, output, LAMPS: right lamps, registered.
- state_code, output, 3: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3. Codes 4..7 are unused.
- seq_count, output, 4: completed pattern periods. Wraps 15→0.

Behaviour:
- Reset (synchronous, priority over everything):
  - Divider = 0, state = IDLE, step = 0.
  - lamp_l = lamp_r = 0, state_code = 0, seq_count = 0.
  - Reset mid-sequence abandons the pattern immediately; no partial completion is counted.
- Divider: counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly one cycle when the divider is at TICK_DIV-1. The first tick comes TICK_DIV cycles after reset deasserts.
- Request decode, evaluated only on tick cycles. Priority:
  - hazard_req, or left_req & right_req → HAZARD
  - else left_req → LEFT
  - else right_req → RIGHT
  - else IDLE
- Requests that change between ticks are ignored.
- LAST (end of a pattern period):
  - LAMPS in LEFT/RIGHT with mode=0.
  - 1 in LEFT/RIGHT with mode=1.
  - 1 in HAZARD, regardless of mode.
- On a tick, state update:
  - Entering IDLE: step ← 0.
  - Entering a non-IDLE state, or mode toggling while in LEFT/RIGHT: step ← 1. The first lamp lights without waiting a full period.
  - Staying in the same non-IDLE state: step ← (step==LAST) ? 0 : step+1.
  - A step wrap LAST→0 increments seq_count, mod 16.
- Lamp pattern for the active side (registered, updated one cycle after state/step/brake change):
  - Sequential: the lowest `step` lamps are on (step 0 = all off, step LAMPS = all on).
  - Flash: all on when step=1, all off when step=0.
  - HAZARD: both sides use the flash pattern in phase.
- Brake overlay (one-cycle latency, not tick-gated):
  - IDLE: both sides all on.
  - LEFT: right side all on.
  - RIGHT: left side all on.
  - HAZARD: brake is ignored.
- Inactive side without brake: all off.
- state_code is registered and mirrors the state register, with the same latency as the lamps.
- Turn-to-turn switch (LEFT→RIGHT directly, on one tick): the new side starts at step 1; the old side goes dark on the same update.

Test Plan (LAMPS=3, TICK_DIV=4):
1. Hold left_req=1, mode=0 from reset release:
   - lamp_l steps 001, 011, 111, 000, 001 on successive ticks (every 4 cycles).
   - lamp_r stays 000; state_code=1.
   - seq_count increments to 1 at the 000 step.
2. Same as 1 with brake=1:
   - lamp_r = 111 one cycle after brake rises.
   - Releasing all requests gives IDLE, with lamp_l = lamp_r = 111 while brake is held.
3. right_req=1, mode=1:
   - lamp_r alternates 111/000 per tick.
   - Toggling mode to 0 mid-flash restarts at 001 on the next tick.
4. left_req=1 and right_req=1 together, brake=1:
   - state_code=3.
   - Both sides flash 111/000 in phase; brake has no effect.
5. Assert reset for one cycle while lamp_l=011:
   - The next cycle shows all outputs 0 and seq_count=0.
   - The first new tick comes 4 cycles after reset drops.
6. Pulse left_req high for 2 cycles between ticks: no state change, lamps remain 000.
